// File: rtl/gc_joybus_sequencer.sv
// rtl/gc_joybus_sequencer.sv - GameCube joybus command decoder and reply serialiser; optional macro GC_ORIGIN_CMD_EN enables the 0x41 origin reply
module gc_joybus_sequencer #(
  parameter int TICKS_PER_US    = 50,
  parameter int IDLE_TIMEOUT_US = 6,
  parameter int REPLY_DELAY_US  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_in,
  output logic        d_oe,
  input  logic [63:0] frame_data,
  input  logic        frame_valid,
  output logic        frame_ready,
  output logic        rumble,
  output logic        busy,
  output logic        cmd_err
);

  localparam logic [15:0] T_1US   = 16'(TICKS_PER_US);
  localparam logic [15:0] T_2US   = 16'(2 * TICKS_PER_US);
  localparam logic [15:0] T_3US   = 16'(3 * TICKS_PER_US);
  localparam logic [15:0] T_4US   = 16'(4 * TICKS_PER_US);
  localparam logic [15:0] T_IDLE  = 16'(IDLE_TIMEOUT_US * TICKS_PER_US);
  localparam logic [15:0] T_REPLY = 16'(REPLY_DELAY_US * TICKS_PER_US);
  localparam logic [63:0] NEUTRAL = 64'h0080_8080_8080_0000;

  typedef enum logic [3:0] {
    IDLE, RX_LOW, RX_HIGH, RX_STOP, WAIT_REPLY, TX_LOW, TX_HIGH, TX_STOP, RECOVER
  } state_t;

  typedef enum logic [1:0] {K_STATUS, K_POLL, K_ORIGIN} kind_t;

  state_t      state, state_nx;
  kind_t       kind, dec_kind;
  logic        dec_known;
  logic [4:0]  dec_len;
  logic        s1, ds;
  logic [15:0] timer;
  logic [6:0]  rx_shift;
  logic [4:0]  bit_cnt, need;
  logic [79:0] tx_shift;
  logic [6:0]  tx_idx, tx_len;
  logic [63:0] held;
  logic        rx_bit, byte_done, rx_complete, handshake, timeout;
  logic [7:0]  cmd_byte;
  logic [15:0] tx_low_t;

  // Short low pulse is a 1; the first eight bits form the command byte.
  assign rx_bit      = (timer < T_2US);
  assign cmd_byte    = {rx_shift, rx_bit};
  assign byte_done   = (state == RX_LOW) && ds && (bit_cnt == 5'd7);
  assign rx_complete = (need != 5'd0) && (bit_cnt == need);
  assign tx_low_t    = tx_shift[79] ? T_1US : T_3US;
  assign handshake   = (state == RX_STOP) && ds && (kind == K_POLL);
  assign timeout     = ds && (timer >= T_IDLE);

  // Command byte to reply kind and total command length in bits.
  always_comb begin
    dec_known = 1'b1;
    dec_kind  = K_STATUS;
    dec_len   = 5'd8;
    case (cmd_byte)
      8'h00: begin
        dec_kind = K_STATUS;
      end
      8'h40: begin
        dec_kind = K_POLL;
        dec_len  = 5'd24;
      end
`ifdef GC_ORIGIN_CMD_EN
      8'h41: begin
        dec_kind = K_ORIGIN;
      end
`endif
      default: dec_known = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; TX states never look at ds so our own drive is not decoded.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       if (!ds) state_nx = RX_LOW;
      RX_LOW:     if (ds) state_nx = (byte_done && !dec_known) ? RECOVER : RX_HIGH;
      RX_HIGH: begin
        if (!ds)          state_nx = rx_complete ? RX_STOP : RX_LOW;
        else if (timeout) state_nx = IDLE;
      end
      RX_STOP:    if (ds) state_nx = WAIT_REPLY;
      WAIT_REPLY: if (timer >= T_REPLY - 16'd1) state_nx = TX_LOW;
      TX_LOW:     if (timer >= tx_low_t - 16'd1) state_nx = TX_HIGH;
      TX_HIGH: begin
        if (timer >= T_4US - tx_low_t - 16'd1)
          state_nx = (tx_idx == tx_len - 7'd1) ? TX_STOP : TX_LOW;
      end
      TX_STOP:    if (timer >= T_2US - 16'd1) state_nx = RECOVER;
      RECOVER:    if (timeout) state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  // Line synchroniser, phase timer, RX shifter, frame hold and TX shifter.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= 1'b1;
      ds       <= 1'b1;
      timer    <= 16'd0;
      rx_shift <= 7'd0;
      bit_cnt  <= 5'd0;
      need     <= 5'd0;
      kind     <= K_STATUS;
      held     <= NEUTRAL;
      rumble   <= 1'b0;
      tx_shift <= 80'd0;
      tx_idx   <= 7'd0;
      tx_len   <= 7'd0;
    end else begin
      s1 <= d_in;
      ds <= s1;
      if (state_nx != state || (state == RECOVER && !ds)) timer <= 16'd0;
      else if (timer != 16'hFFFF)                         timer <= timer + 16'd1;
      if (state == IDLE) begin
        bit_cnt <= 5'd0;
        need    <= 5'd0;
      end
      if (state == RX_LOW && ds) begin
        rx_shift <= cmd_byte[6:0];
        bit_cnt  <= bit_cnt + 5'd1;
        if (byte_done) begin
          need <= dec_len;
          kind <= dec_kind;
        end
      end
      if (handshake) begin
        if (frame_valid) held <= frame_data;
        rumble <= rx_shift[0];
      end
      if (state == WAIT_REPLY && state_nx == TX_LOW) begin
        tx_idx <= 7'd0;
        case (kind)
          K_POLL: begin
            tx_shift <= {held, 16'h0000};
            tx_len   <= 7'd64;
          end
          K_ORIGIN: begin
            tx_shift <= {NEUTRAL, 16'h0000};
            tx_len   <= 7'd80;
          end
          default: begin
            tx_shift <= {24'h090000, 56'd0};
            tx_len   <= 7'd24;
          end
        endcase
      end
      if (state == TX_HIGH && state_nx != TX_HIGH) begin
        tx_shift <= {tx_shift[78:0], 1'b0};
        tx_idx   <= tx_idx + 7'd1;
      end
    end
  end

  // Outputs decoded from state; pulses are suppressed while rst is high.
  always_comb begin
    d_oe        = (state == TX_LOW) || (state == TX_STOP);
    busy        = (state != IDLE);
    frame_ready = !rst && handshake && frame_valid;
    cmd_err     = !rst && ((byte_done && !dec_known) || (state == RX_HIGH && timeout));
  end

endmodule

// File: doc/gc_joybus_sequencer.md
Name: gc_joybus_sequencer

Overview:
- Sequences the GameCube controller single-wire link: decodes console commands on the open-drain data line and selects the response.
- Serialises the response with joybus bit timing and handshakes fresh 64-bit input frames from the TAS frame source.
- Sits between the pad-level tristate on `d` and the frame buffer that feeds `gc_controller`.
- Sole owner of the line-drive decision.

Parameters:
- TICKS_PER_US, 50, clk cycles per microsecond; all joybus timing derives from it.
- IDLE_TIMEOUT_US, 6, line-high time in µs that aborts a partial command.
- REPLY_DELAY_US, 2, line-high gap in µs between console stop bit and first response bit.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- d_in  in  1  raw level of the `d` pad; asynchronous, synchronised internally by 2 flops
- d_oe  out  1  1 = drive `d` low; 0 = release (pull-up)
- frame_data  in  64  next input frame, GC poll layout
- frame_valid  in  1  frame_data holds an unconsumed frame
- frame_ready  out  1  one-cycle pulse; frame_data consumed this cycle
- rumble  out  1  bit 0 of the last poll's third command byte
- busy  out  1  high in any state other than IDLE
- cmd_err  out  1  one-cycle pulse on an aborted or unknown command

Behaviour:
- Interface: one clock, `clk`; reset `rst` is synchronous and active-high.
- Reset values: d_oe=0, frame_ready=0, rumble=0, busy=0, cmd_err=0, state=IDLE.
- Reset values (cont.): held frame = 64'h0080_8080_8080_0000 (neutral pad), bit/byte counters = 0.
- rst asserted mid-transmit releases d_oe at the next edge.
- Sampling: all decisions use the synchronised line `ds`. Latency from pad to `ds` is 2 cycles.
- Low-time counter is 16 bits and saturates.
- RX bit decode: measure each low pulse. Low < 2 µs → 1; low ≥ 2 µs → 0. Bits are MSB first.
- Command length comes from byte 0:
  - 0x00 (status) → 1 byte.
  - 0x40 (poll) → 3 bytes.
  - 0x41 (origin) → 1 byte.
  - Any other value → unknown: pulse cmd_err, go to RECOVER.
- The console stop bit is the low pulse that follows the final command bit.
- States:
  - IDLE: on ds falling → RX_LOW.
  - RX_LOW: on ds rising → shift in the decoded bit, go to RX_HIGH.
  - RX_HIGH:
    - On ds falling with the command incomplete → RX_LOW.
    - On ds falling with the command complete → RX_STOP.
    - If high ≥ IDLE_TIMEOUT_US → cmd_err, IDLE.
  - RX_STOP: on ds rising → WAIT_REPLY, and perform the frame handshake.
  - WAIT_REPLY: hold for REPLY_DELAY_US → TX_LOW with bit index 0.
  - TX_LOW: a 0 bit drives low 3 µs, a 1 bit drives low 1 µs → TX_HIGH.
  - TX_HIGH: releases for the remainder of the 4 µs bit cell, then either the next bit → TX_LOW, or after the last bit → TX_STOP.
  - TX_STOP: drive low 2 µs, release → RECOVER.
  - RECOVER: wait until ds has been high continuously for IDLE_TIMEOUT_US → IDLE.
- Any ds low observed during RECOVER restarts the RECOVER high-time count.
- Responses are sent MSB first:
  - Status: 24 bits, 0x090000.
  - Poll: 64 bits, the held frame.
  - Origin: 80 bits, 64'h0080_8080_8080_0000 followed by 16'h0000.
- Frame handshake, on poll only, on the RX_STOP→WAIT_REPLY edge:
  - If frame_valid=1: held frame ← frame_data, frame_ready=1 for that cycle.
  - If frame_valid=0: held frame unchanged (repeat the last frame), no pulse.
  - frame_valid rising at any other time has no effect until the next poll.
  - rumble updates on the same edge.
- While the block drives (d_oe=1), RX logic ignores ds. No echo decode.
- frame_ready and cmd_err never assert in the same cycle.

Optional Feature:
- Macro: GC_ORIGIN_CMD_EN.
- When defined: 0x41 is decoded and answered with the 80-bit origin response.
- When undefined: 0x41 is treated as unknown (cmd_err pulse, RECOVER, no drive).
- Other commands are unaffected.

Test Plan:
- rst held 3 cycles during TX_LOW of a poll reply → d_oe=0 at the first edge with rst high; all outputs at their reset values; state IDLE after rst falls.
- Console sends 0x00 + stop → 2 µs after stop rise, the bench decodes 0x090000 from d_oe pulse widths (1 µs/3 µs lows), then a 2 µs stop low; busy falls after RECOVER.
- frame_valid=1, frame_data=64'h0123_4567_89AB_CDEF; poll 0x40 0x03 0x01 → frame_ready pulses exactly once at stop rise; reply = 0x0123456789ABCDEF; rumble=1.
- Second poll with frame_valid=0 → no frame_ready; reply repeats 0x0123456789ABCDEF.
- Console sends 0x40, then leaves the line high 7 µs → cmd_err single pulse, d_oe never asserted, state IDLE.
- Command 0x41 + stop → with GC_ORIGIN_CMD_EN, 80-bit 0x0080808080800000_0000 reply; without it, cmd_err pulse and no drive.
